// File: rtl/pcpi_pkg.sv
// Shared types and constants for the PCPI initiator and its timeout counter.
// The timeout counter is built only when PCPI_TIMEOUT_EN is defined.
package pcpi_pkg;

  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic        wr;
    logic [31:0] rd;
    logic        illegal;
  } rsp_t;

  function automatic rsp_t make_rsp(input logic wr, input logic [31:0] rd, input logic illegal);
    rsp_t r;
    r.wr      = wr;
    r.rd      = rd;
    r.illegal = illegal;
    return r;
  endfunction

endpackage

// File: rtl/pcpi_timeout.sv
// Counts idle ISSUE cycles; expired_o flags the last cycle before the
// instruction must be declared illegal. Used only when PCPI_TIMEOUT_EN is defined.
module pcpi_timeout
  import pcpi_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear_i,
  input  logic wait_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturate at LAST so the count cannot wrap while the FSM reacts.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || wait_i) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/pcpi_initiator.sv
// Core-side bridge that issues one instruction at a time to a PCPI coprocessor
// and returns its result; PCPI_TIMEOUT_EN adds an illegal-instruction timeout.
module pcpi_initiator
  import pcpi_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_insn,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready,
  output logic        rsp_valid,
  output logic        rsp_wr,
  output logic [31:0] rsp_rd,
  output logic        rsp_illegal,
  input  logic        rsp_ready
);

  state_e      state_q, state_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  rsp_t        rsp_q, rsp_d;
  logic        timeout_hit;

`ifdef PCPI_TIMEOUT_EN
  logic expired;

  // Holding clear outside ISSUE guarantees a zero count on entry.
  pcpi_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .resetn    (resetn),
    .clear_i   (state_q != ISSUE),
    .wait_i    (pcpi_wait),
    .expired_o (expired)
  );

  assign timeout_hit = expired & ~pcpi_wait;
  assign rsp_illegal = rsp_q.illegal;
`else
  logic unused_cfg;

  assign timeout_hit = 1'b0;
  assign rsp_illegal = 1'b0;
  assign unused_cfg  = pcpi_wait & rsp_q.illegal & (TIMEOUT != 0);
`endif

  always_comb begin
    state_d = state_q;
    insn_d  = insn_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rsp_d   = rsp_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          insn_d  = req_insn;
          rs1_d   = req_rs1;
          rs2_d   = req_rs2;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // A ready in the same cycle as expiry wins over the timeout.
        if (pcpi_ready) begin
          rsp_d   = make_rsp(pcpi_wr, pcpi_rd, 1'b0);
          state_d = RESP;
        end else if (timeout_hit) begin
          rsp_d   = make_rsp(1'b0, 32'd0, 1'b1);
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      insn_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      insn_q  <= insn_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rsp_q   <= rsp_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign pcpi_valid = (state_q == ISSUE);
  assign rsp_valid  = (state_q == RESP);
  assign pcpi_insn  = insn_q;
  assign pcpi_rs1   = rs1_q;
  assign pcpi_rs2   = rs2_q;
  assign rsp_wr     = rsp_q.wr;
  assign rsp_rd     = rsp_q.rd;

endmodule

// File: tb/tb_pcpi_initiator.sv
// Directed self-checking bench for pcpi_initiator; the timeout scenarios adapt
// to whether PCPI_TIMEOUT_EN is defined.
module tb_pcpi_initiator;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic [31:0] reqInsn = '0;
  logic [31:0] reqRs1 = '0;
  logic [31:0] reqRs2 = '0;
  logic        pcpiValid;
  logic [31:0] pcpiInsn, pcpiRs1, pcpiRs2;
  logic        pcpiWr = 1'b0;
  logic [31:0] pcpiRd = '0;
  logic        pcpiWait = 1'b0;
  logic        pcpiReady = 1'b0;
  logic        rspValid, rspWr, rspIllegal;
  logic [31:0] rspRd;
  logic        rspReady = 1'b0;

  int vecCount  = 0;
  int missCount = 0;

  pcpi_initiator #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_valid   (reqValid),
    .req_ready   (reqReady),
    .req_insn    (reqInsn),
    .req_rs1     (reqRs1),
    .req_rs2     (reqRs2),
    .pcpi_valid  (pcpiValid),
    .pcpi_insn   (pcpiInsn),
    .pcpi_rs1    (pcpiRs1),
    .pcpi_rs2    (pcpiRs2),
    .pcpi_wr     (pcpiWr),
    .pcpi_rd     (pcpiRd),
    .pcpi_wait   (pcpiWait),
    .pcpi_ready  (pcpiReady),
    .rsp_valid   (rspValid),
    .rsp_wr      (rspWr),
    .rsp_rd      (rspRd),
    .rsp_illegal (rspIllegal),
    .rsp_ready   (rspReady)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
    checkOutput("req_ready before issue", reqReady, 1);
    reqValid = 1'b1;
    reqInsn  = insn;
    reqRs1   = rs1;
    reqRs2   = rs2;
    step();
    reqValid = 1'b0;
    reqInsn  = '0;
    checkOutput("pcpi_valid after accept", pcpiValid, 1);
    checkOutput("pcpi_insn", pcpiInsn, insn);
    checkOutput("pcpi_rs1", pcpiRs1, rs1);
    checkOutput("pcpi_rs2", pcpiRs2, rs2);
    checkOutput("req_ready in ISSUE", reqReady, 0);
  endtask

  task automatic respond(input logic wr, input logic [31:0] rd);
    pcpiReady = 1'b1;
    pcpiWr    = wr;
    pcpiRd    = rd;
    step();
    pcpiReady = 1'b0;
    pcpiWr    = 1'b0;
    checkOutput("pcpi_valid after ready", pcpiValid, 0);
    checkOutput("rsp_valid after ready", rspValid, 1);
  endtask

  task automatic drainResponse();
    checkOutput("req_ready in RESP", reqReady, 0);
    rspReady = 1'b1;
    step();
    rspReady = 1'b0;
    checkOutput("rsp_valid after drain", rspValid, 0);
    checkOutput("req_ready after drain", reqReady, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;

    // Reset state.
    step();
    checkOutput("reset pcpi_valid", pcpiValid, 0);
    checkOutput("reset rsp_valid", rspValid, 0);
    checkOutput("reset rsp_rd", rspRd, 0);
    checkOutput("reset rsp_illegal", rspIllegal, 0);
    checkOutput("reset pcpi_insn", pcpiInsn, 0);
    resetn = 1'b1;
    step();
    checkOutput("req_ready after reset", reqReady, 1);

    // Basic MUL: 7 * 6 = 42, coprocessor answers on the third ISSUE cycle.
    applyStimulus(32'h02B50533, 32'd7, 32'd6);
    step();
    checkOutput("mul insn stable", pcpiInsn, 32'h02B50533);
    checkOutput("mul no early rsp", rspValid, 0);
    step();
    respond(1'b1, 32'd42);
    checkOutput("mul rsp_rd", rspRd, 32'd42);
    checkOutput("mul rsp_wr", rspWr, 1);
    checkOutput("mul rsp_illegal", rspIllegal, 0);
    drainResponse();

    // Silent coprocessor.
    applyStimulus(32'h0000000B, 32'd1, 32'd2);
    pcpiWr = 1'b1;
    pcpiRd = 32'hDEADBEEF;
`ifdef PCPI_TIMEOUT_EN
    n = 0;
    while (!rspValid && n < 40) begin
      if (pcpiValid) n++;
      step();
    end
    pcpiWr = 1'b0;
    checkOutput("timeout issue cycles", n, 16);
    checkOutput("timeout rsp_valid", rspValid, 1);
    checkOutput("timeout rsp_illegal", rspIllegal, 1);
    checkOutput("timeout rsp_rd", rspRd, 0);
    checkOutput("timeout rsp_wr", rspWr, 0);
`else
    n = 0;
    repeat (40) begin
      step();
      if (rspValid) n++;
    end
    pcpiWr = 1'b0;
    checkOutput("no-timeout rsp_valid count", n, 0);
    checkOutput("no-timeout pcpi_valid held", pcpiValid, 1);
    respond(1'b0, 32'h00000BAD);
    checkOutput("no-timeout rsp_illegal", rspIllegal, 0);
    checkOutput("no-timeout rsp_rd", rspRd, 32'h00000BAD);
`endif
    drainResponse();

    // Busy extension: wait held for 40 cycles.
    applyStimulus(32'h02C5C6B3, 32'hFFFFFFFF, 32'd1);
    pcpiWait = 1'b1;
    n = 0;
    repeat (40) begin
      step();
      if (rspValid || !pcpiValid) n++;
    end
    checkOutput("busy no early rsp", n, 0);
    pcpiWait = 1'b0;
    respond(1'b1, 32'hFFFFFFFF);
    checkOutput("busy rsp_illegal", rspIllegal, 0);
    checkOutput("busy rsp_rd", rspRd, 32'hFFFFFFFF);
    drainResponse();

    // Ready arrives in the cycle the counter reaches 15.
    applyStimulus(32'h02D74733, 32'd5, 32'd17);
    repeat (15) step();
    checkOutput("simul still issuing", pcpiValid, 1);
    respond(1'b1, 32'h00000055);
    checkOutput("simul rsp_illegal", rspIllegal, 0);
    checkOutput("simul rsp_rd", rspRd, 32'h00000055);
    checkOutput("simul rsp_wr", rspWr, 1);
    drainResponse();

    // Backpressure: result must hold while the coprocessor bus churns.
    applyStimulus(32'h02E7D7B3, 32'd3, 32'd4);
    respond(1'b0, 32'h00001234);
    reqValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pcpiRd    = (i % 2 == 0) ? 32'hA5A5A5A5 : 32'h5A5A5A5A;
      pcpiWr    = 1'b1;
      pcpiReady = (i % 2 == 0);
      step();
      checkOutput("bp rsp_rd held", rspRd, 32'h00001234);
      checkOutput("bp rsp_wr held", rspWr, 0);
      checkOutput("bp rsp_valid held", rspValid, 1);
      checkOutput("bp req_ready low", reqReady, 0);
    end
    reqValid  = 1'b0;
    pcpiReady = 1'b0;
    pcpiWr    = 1'b0;
    drainResponse();

    // Reset in the middle of ISSUE drops the request.
    applyStimulus(32'h02C58633, 32'd9, 32'd9);
    step();
    resetn = 1'b0;
    #1;
    checkOutput("mid reset pcpi_valid", pcpiValid, 0);
    checkOutput("mid reset pcpi_insn", pcpiInsn, 0);
    step();
    resetn = 1'b1;
    step();
    checkOutput("post reset req_ready", reqReady, 1);
    n = 0;
    repeat (4) begin
      step();
      if (rspValid || pcpiValid) n++;
    end
    checkOutput("post reset no response", n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
